keccak_share_arbiter: RTL and testbench
=======================================

// Module: keccak_share_arbiter
// PURPOSE
//  Shares the single Keccak permutation core among N_REQ requesters (SampleInBall, ExpandA,
//  ExpandMask, ...). Grants one requester a multi-squeeze session, forwards its start,
//  state and rho_en to the core, and returns a per-requester done pulse.
//  Sessions are locked: the owner keeps the core across successive permutations until it
//  drops req. Fairness between sessions is round-robin.
// PARAMETERS
//  N_REQ   3     number of requesters (2..8)
//  W       1600  Keccak state width in bits
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous, active-low reset
//  req            in   N_REQ      level; high = requester wants/holds a session
//  start          in   N_REQ      level; owner requests one permutation
//  data_in        in   N_REQ*W    per-requester state; slice k = [k*W +: W]
//  rho_en_in      in   N_REQ      per-requester absorb-seed select
//  core_done      in   1          core permutation complete (1-cycle pulse)
//  core_out       in   W          core state; broadcast to all requesters, unregistered
//  gnt            out  N_REQ      one-hot session owner (registered)
//  done_out       out  N_REQ      1-cycle pulse to the owner when its permutation finishes
//  core_start     out  1          level start to core, held until core_done
//  core_in        out  W          registered state for the core
//  core_rho_en    out  1          registered rho_en for the core
//  core_rst_n     out  1          synchronous core soft reset, active low
//  busy           out  1          high in any state other than IDLE
//  perm_count     out  16         permutations completed since reset; wraps at 0xFFFF
// BEHAVIOUR
//  Reset values: gnt=0, done_out=0, core_start=0, core_in=0, core_rho_en=0, core_rst_n=0,
//   busy=0, perm_count=0, rr_ptr=0, state=IDLE. Reset mid-session aborts it immediately.
//  States: IDLE, LOCKED, RUN, DELIVER, FLUSH.
//  IDLE: core_rst_n=0. If any req is high, pick the first requester at or above rr_ptr,
//   searching upward with wrap-around. Set gnt one cycle later and go to LOCKED.
//  LOCKED: core_rst_n=1.
//   - If req[own]=0: go to FLUSH.
//   - Else if start[own]=1: latch core_in<=data_in[own], core_rho_en<=rho_en_in[own],
//     core_start<=1, and go to RUN.
//   - start from a non-owner is ignored in every state.
//  RUN: hold core_start=1 and core_in stable. On core_done: core_start<=0, perm_count++.
//   - If req[own] is still high: go to DELIVER.
//   - If req[own] dropped during RUN: skip the done pulse and go to FLUSH.
//   The core_done edge never yields a second start within the same permutation.
//  DELIVER: done_out[own]=1 for exactly one cycle, then go to LOCKED.
//   done_out arrives 1 cycle after core_done.
//   The owner may reassert start in that same LOCKED cycle, so back-to-back squeezes cost
//   2 idle cycles between core_done and the next core_start.
//  FLUSH: core_rst_n=0 for one cycle, gnt<=0, rr_ptr<=(own+1) mod N_REQ, go to IDLE.
//   The next grant is therefore at least 2 cycles after req falls.
//  core_done outside RUN is ignored and does not count.
//  gnt is always one-hot or zero. done_out is never asserted to a non-owner.
//  perm_count wraps from 0xFFFF to 0.
// TESTING
//  1. Single requester: req[0]=1, start[0]=1, core_done 24 cycles later ->
//     gnt=001, core_start high for 24 cycles, done_out=001 for 1 cycle, perm_count=1.
//  2. Multi-squeeze: req[1] held, 3 start/done rounds with distinct data_in ->
//     gnt stays 010 throughout, 3 done pulses, core_in matches each round's slice,
//     perm_count=3.
//  3. Round-robin: req=111 continuously, each owner does 1 permutation then drops req ->
//     grant order is 0, 1, 2, 0; a requester re-raising req waits its turn.
//  4. Abort: req[2] falls during RUN -> no done_out, FLUSH pulses core_rst_n low 1 cycle,
//     gnt=000, next grant goes to requester 0.
//  5. Noise: start[1]=1 while requester 0 owns and core_done pulses in LOCKED ->
//     core_start unchanged, perm_count unchanged.
//  6. Reset mid-RUN -> all outputs return to reset values next cycle; a new req is granted
//     normally afterwards.

Source files
------------

// File: rtl/keccak_share_arbiter.sv
// Keccak core arbiter: locked multi-squeeze sessions with round-robin
// fairness between requesters sharing one permutation core.
module keccak_share_arbiter #(
  parameter int N_REQ = 3,
  parameter int W     = 1600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   start,
  input  logic [N_REQ*W-1:0] data_in,
  input  logic [N_REQ-1:0]   rho_en_in,
  input  logic               core_done,
  input  logic [W-1:0]       core_out,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done_out,
  output logic               core_start,
  output logic [W-1:0]       core_in,
  output logic               core_rho_en,
  output logic               core_rst_n,
  output logic               busy,
  output logic [15:0]        perm_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOCKED,
    RUN,
    DELIVER,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    own_q, own_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    pick;
  logic             pick_ok;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             cs_q, cs_d;
  logic [W-1:0]     cin_q, cin_d;
  logic             rho_q, rho_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             req_own;
  logic             start_own;
  logic             unused_core_out;

  // Core state goes straight to the requesters outside this block.
  assign unused_core_out = ^core_out;

  assign req_own   = req[own_q];
  assign start_own = start[own_q];

  // First requesting index at or above the round-robin pointer, wrapping.
  always_comb begin
    int k;
    k       = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req[k]) begin
        pick    = IW'(k);
        pick_ok = 1'b1;
      end
    end
  end

  // Session sequencing and datapath next values.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cs_d    = cs_q;
    cin_d   = cin_q;
    rho_d   = rho_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          own_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (!req_own) begin
          state_d = FLUSH;
        end else if (start_own) begin
          cin_d   = data_in[int'(own_q)*W +: W];
          rho_d   = rho_en_in[own_q];
          cs_d    = 1'b1;
          drop_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        drop_d = drop_q | ~req_own;
        if (core_done) begin
          cs_d    = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = drop_d ? FLUSH : DELIVER;
        end
      end
      DELIVER: begin
        state_d = LOCKED;
      end
      FLUSH: begin
        gnt_d   = '0;
        ptr_d   = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      cin_q   <= '0;
      rho_q   <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      cin_q   <= cin_d;
      rho_q   <= rho_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign gnt         = gnt_q;
  assign done_out    = (state_q == DELIVER) ? gnt_q : '0;
  assign core_start  = cs_q;
  assign core_in     = cin_q;
  assign core_rho_en = rho_q;
  assign core_rst_n  = (state_q == LOCKED) ||
                       (state_q == RUN) ||
                       (state_q == DELIVER);
  assign busy        = (state_q != IDLE);
  assign perm_count  = cnt_q;

endmodule

// File: tb/tb_keccak_share_arbiter.sv
// Bench for keccak_share_arbiter: session-level reference model,
// directed scenarios and randomized traffic.
module tb_keccak_share_arbiter;

  localparam int N = 3;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   start = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   rho_en_in = '0;
  logic           core_done = 1'b0;
  logic [W-1:0]   core_out = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done_out;
  logic           core_start;
  logic [W-1:0]   core_in;
  logic           core_rho_en;
  logic           core_rst_n;
  logic           busy;
  logic [15:0]    perm_count;

  int tests = 0;
  int fails = 0;

  keccak_share_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .start(start),
    .data_in(data_in), .rho_en_in(rho_en_in),
    .core_done(core_done), .core_out(core_out),
    .gnt(gnt), .done_out(done_out), .core_start(core_start),
    .core_in(core_in), .core_rho_en(core_rho_en),
    .core_rst_n(core_rst_n), .busy(busy), .perm_count(perm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core stand-in: finishes after a latency, optionally emits stray done.
  int lat_fix = 0;
  int lat_cnt = 0;
  int lat_tgt = 1;
  bit noise_en = 0;
  bit force_done = 0;
  always @(posedge clk) begin
    #2;
    core_done = 1'b0;
    core_out = {$urandom, $urandom};
    if (!rst_n) begin
      lat_cnt = 0;
    end else if (core_start) begin
      if (lat_cnt == 0)
        lat_tgt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 8));
      lat_cnt++;
      if (lat_cnt >= lat_tgt) begin
        core_done = 1'b1;
        lat_cnt = 0;
      end
    end else begin
      lat_cnt = 0;
      if (force_done) begin
        core_done = 1'b1;
        force_done = 0;
      end else if (noise_en && $urandom_range(0, 9) == 0) begin
        core_done = 1'b1;
      end
    end
  end

  // Reference model: which requester holds a session and what it is doing.
  typedef enum {FREE, GRANTED, PERMUTING, NOTIFYING, RELEASING} phase_t;
  phase_t      ph = FREE;
  int          owner = 0;
  int          next_turn = 0;
  bit          m_run = 0;
  logic [W-1:0] m_in = '0;
  bit          m_rho = 0;
  int          m_perms = 0;
  bit          m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = FREE; owner = 0; next_turn = 0; m_run = 0;
      m_in = '0; m_rho = 0; m_perms = 0; m_left = 0;
    end else begin
      case (ph)
        FREE: if (req != 0) begin
          for (int i = N - 1; i >= 0; i--)
            if (req[(next_turn + i) % N]) owner = (next_turn + i) % N;
          ph = GRANTED;
        end
        GRANTED: if (!req[owner]) ph = RELEASING;
        else if (start[owner]) begin
          m_in = data_in[owner*W +: W];
          m_rho = rho_en_in[owner];
          m_run = 1; m_left = 0; ph = PERMUTING;
        end
        PERMUTING: begin
          if (!req[owner]) m_left = 1;
          if (core_done) begin
            m_run = 0;
            m_perms = (m_perms + 1) % 65536;
            ph = m_left ? RELEASING : NOTIFYING;
          end
        end
        NOTIFYING: ph = GRANTED;
        RELEASING: begin
          next_turn = (owner + 1) % N;
          ph = FREE;
        end
      endcase
    end
  end

  // Every cycle compare DUT outputs with the model.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = '0;
    if (ph != FREE) eg[owner] = 1'b1;
    if (!rst_n) begin
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_done", 64'(done_out), 64'd0);
      check("rst_cstart", 64'(core_start), 64'd0);
      check("rst_cin", core_in, 64'd0);
      check("rst_rho", 64'(core_rho_en), 64'd0);
      check("rst_crst", 64'(core_rst_n), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cnt", 64'(perm_count), 64'd0);
    end else begin
      check("gnt", 64'(gnt), 64'(eg));
      check("done_out", 64'(done_out), (ph == NOTIFYING) ? 64'(eg) : 64'd0);
      check("core_start", 64'(core_start), 64'(m_run));
      check("core_in", core_in, m_in);
      check("core_rho_en", 64'(core_rho_en), 64'(m_rho));
      check("core_rst_n", 64'(core_rst_n),
            64'(ph == GRANTED || ph == PERMUTING || ph == NOTIFYING));
      check("busy", 64'(busy), 64'(ph != FREE));
      check("perm_count", 64'(perm_count), 64'(m_perms));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0; req = '0; start = '0; lat_fix = 0; noise_en = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // what: 0 done_out, 1 gnt nonzero, 2 gnt zero, 3 core_start high
  task automatic wait_for(input int what, input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((what == 0 && done_out != 0) || (what == 1 && gnt != 0) ||
          (what == 2 && gnt == 0) || (what == 3 && core_start)) begin
        ok = 1;
        break;
      end
    end
    check(nm, 64'(ok), 64'd1);
  endtask

  int exp_order[4] = '{0, 1, 2, 0};

  initial begin
    int n;
    int dcnt;
    bit flushed;
    bit got;
    logic [W-1:0] d;

    // 1: single requester, 24-cycle permutation
    do_reset();
    check("reset_count", 64'(perm_count), 64'd0);
    req = 3'b001; start = 3'b001; lat_fix = 24;
    n = 0; got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (core_start) n++;
      if (done_out != 0) got = 1;
    end
    check("t1_done_seen", 64'(got), 64'd1);
    check("t1_done_val", 64'(done_out), 64'h1);
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_start_cycles", 64'(n), 64'd24);
    tick();
    start = '0;
    repeat (4) @(negedge clk);
    check("t1_count", 64'(perm_count), 64'd1);

    // 2: multi-squeeze on requester 1
    do_reset();
    req = 3'b010; lat_fix = 0;
    wait_for(1, "t2_grant");
    check("t2_gnt", 64'(gnt), 64'h2);
    for (int r = 0; r < 3; r++) begin
      tick();
      d = {$urandom, $urandom};
      data_in[W +: W] = d;
      data_in[0 +: W] = ~d;
      rho_en_in = 3'(r);
      start = 3'b010;
      wait_for(0, "t2_done");
      check("t2_core_in", core_in, d);
      check("t2_gnt_hold", 64'(gnt), 64'h2);
      tick();
      start = '0;
    end
    repeat (2) @(negedge clk);
    check("t2_count", 64'(perm_count), 64'd3);

    // 3: round-robin with re-raised requests
    do_reset();
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      int idx;
      wait_for(1, "t3_grant");
      idx = -1;
      for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
      check("t3_order", 64'(idx), 64'(exp_order[r]));
      tick();
      if (idx >= 0) start[idx] = 1'b1;
      wait_for(0, "t3_done");
      tick();
      start = '0;
      if (idx >= 0) req[idx] = 1'b0;
      wait_for(2, "t3_release");
      tick();
      req = 3'b111;
    end
    req = '0;

    // 4: owner abandons during a permutation
    do_reset();
    req = 3'b100; start = 3'b100; lat_fix = 20;
    wait_for(3, "t4_run");
    repeat (3) tick();
    req = '0; start = '0;
    dcnt = 0; flushed = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_out != 0) dcnt++;
      if (gnt != 0 && !core_rst_n) flushed = 1;
    end
    check("t4_no_done", 64'(dcnt), 64'd0);
    check("t4_flush", 64'(flushed), 64'd1);
    check("t4_gnt_clear", 64'(gnt), 64'd0);
    check("t4_count", 64'(perm_count), 64'd1);
    tick();
    req = 3'b101;
    wait_for(1, "t4_regrant");
    check("t4_next_owner", 64'(gnt), 64'h1);
    req = '0;

    // 5: non-owner start and stray core_done
    do_reset();
    req = 3'b001;
    wait_for(1, "t5_grant");
    tick();
    start = 3'b010;
    force_done = 1;
    repeat (6) @(negedge clk);
    check("t5_core_start", 64'(core_start), 64'd0);
    check("t5_count", 64'(perm_count), 64'd0);
    check("t5_gnt", 64'(gnt), 64'h1);

    // 6: reset in the middle of a permutation
    do_reset();
    req = 3'b001; start = 3'b001; lat_fix = 30;
    wait_for(3, "t6_run");
    repeat (10) tick();
    rst_n = 0; req = '0; start = '0;
    #1;
    check("t6_cstart", 64'(core_start), 64'd0);
    check("t6_gnt", 64'(gnt), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_crst", 64'(core_rst_n), 64'd0);
    tick();
    rst_n = 1; req = 3'b001;
    wait_for(1, "t6_regrant");
    check("t6_gnt_after", 64'(gnt), 64'h1);

    // Randomized traffic with stray core_done pulses
    do_reset();
    lat_fix = 0; noise_en = 1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      start = 3'($urandom);
      rho_en_in = 3'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    noise_en = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
